// File: rtl/minimips_pkg.sv
// -----------------------------------------------------------------------------
// minimips_pkg
// Shared types and constants for the MiniMIPS fetch sequencer.
//   fetch_state_t        : sequencer state encoding
//   INSTR_W              : instruction width
//   OPCODE_MSB/LSB       : opcode field position inside an instruction
//   HALT_OPCODE_DEFAULT  : opcode value that stops the sequencer
//   is_halt()            : opcode-field compare helper
// -----------------------------------------------------------------------------
package minimips_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_HALT
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0]  instr,
                                   input logic [OPCODE_W-1:0] halt_opcode);
    return instr[OPCODE_MSB:OPCODE_LSB] == halt_opcode;
  endfunction

endpackage

// File: rtl/minimips_pc_unit.sv
// -----------------------------------------------------------------------------
// minimips_pc_unit
// Program counter register.
//   clk, rst_n  : clock, asynchronous active-low reset (PC -> 0)
//   clear_i     : load 0 (program start / restart)
//   load_i      : load target_i (branch/jump redirect)
//   target_i    : redirect word address
//   inc_i       : advance by one word, wrapping modulo 2^AW
//   pc_o        : current PC
// clear_i and load_i are never raised together by the sequencer; clear_i is
// given priority so a start always begins at address 0.
// -----------------------------------------------------------------------------
module minimips_pc_unit #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [AW-1:0] target_i,
  input  logic          inc_i,
  output logic [AW-1:0] pc_o
);

  logic [AW-1:0] pc_d, pc_q;

  // NOTE: every signal assigned in always_comb gets a default on entry;
  // a path that skips the assignment would infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (clear_i)     pc_d = '0;
    else if (load_i) pc_d = target_i;
    else if (inc_i)  pc_d = pc_q + AW'(1);  // natural wrap at 2^AW
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // their inputs from the same edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/minimips_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// minimips_fetch_sequencer
// Fetches 16-bit instructions from a synchronous instruction memory and issues
// them to the MiniMIPS datapath over a valid/ready handshake.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin at PC 0 when idle or halted
//   imem_rd_en      : memory read strobe (FETCH)
//   imem_addr       : memory word address (= pc)
//   imem_rdata      : memory data, valid the cycle after imem_rd_en
//   instr_out       : instruction register to the datapath
//   instr_valid     : instr_out holds an unissued instruction (ISSUE)
//   core_ready      : datapath accepts instr_out this cycle
//   branch_taken    : redirect request, honoured in FETCH/WAIT/ISSUE
//   branch_target   : redirect word address
//   pc              : current PC
//   halted          : halt opcode reached
//   busy            : in FETCH, WAIT or ISSUE
//   issued_cnt      : accepted instructions, saturating at 16'hFFFF
// Each instruction takes FETCH -> WAIT -> ISSUE, so with core_ready held high
// the sequencer issues one instruction every three cycles.
// -----------------------------------------------------------------------------
module minimips_fetch_sequencer
  import minimips_pkg::*;
#(
  parameter int                  IMEM_AW     = 8,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_rd_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               core_ready,
  input  logic               branch_taken,
  input  logic [IMEM_AW-1:0] branch_target,
  output logic [IMEM_AW-1:0] pc,
  output logic               halted,
  output logic               busy,
  output logic [15:0]        issued_cnt
);

  fetch_state_t       state_d, state_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [15:0]        issued_cnt_d, issued_cnt_q;
  logic               rd_en_q, valid_q, halted_q, busy_q;
  logic               pc_clear, pc_load, pc_inc;

  minimips_pc_unit #(.AW(IMEM_AW)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (pc_clear),
    .load_i   (pc_load),
    .target_i (branch_target),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    issued_cnt_d = issued_cnt_q;
    pc_clear     = 1'b0;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_clear     = 1'b1;
          issued_cnt_d = '0;
          state_d      = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // A redirect here simply re-fetches from the target; the read issued
        // this cycle is never captured.
        if (branch_taken) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Redirect beats capture, including a halt word in flight.
        if (branch_taken) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
        end else begin
          instr_d = imem_rdata;
          state_d = is_halt(imem_rdata, HALT_OPCODE) ? ST_HALT : ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // An accepted instruction counts even when a redirect arrives in the
        // same cycle; the redirect only decides where the next fetch goes.
        if (core_ready && issued_cnt_q != 16'hFFFF)
          issued_cnt_d = issued_cnt_q + 16'd1;
        if (branch_taken) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
        end else if (core_ready) begin
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are
  // glitch-free and line up with the state they describe.
  // NOTE: the instruction register is a single word with a defined reset value,
  // so it is reset with the rest of the state rather than left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      issued_cnt_q <= '0;
      rd_en_q      <= 1'b0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      issued_cnt_q <= issued_cnt_d;
      rd_en_q      <= (state_d == ST_FETCH);
      valid_q      <= (state_d == ST_ISSUE);
      halted_q     <= (state_d == ST_HALT);
      busy_q       <= (state_d == ST_FETCH) || (state_d == ST_WAIT) ||
                      (state_d == ST_ISSUE);
    end
  end

  assign imem_rd_en  = rd_en_q;
  assign imem_addr   = pc;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign busy        = busy_q;
  assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_minimips_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_minimips_fetch_sequencer
// Self-checking bench for minimips_fetch_sequencer: directed scenarios plus a
// randomized run against a program-level reference model (the expected
// instruction at each accept is mem[model_pc], with model_pc following the
// sequential/redirect rules).
// -----------------------------------------------------------------------------
module tb_minimips_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        core_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic [7:0]  pc;
  logic        halted;
  logic        busy;
  logic [15:0] issued_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] mem [256];

  minimips_fetch_sequencer #(.IMEM_AW(8), .HALT_OPCODE(4'b1111)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .core_ready    (core_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .halted        (halted),
    .busy          (busy),
    .issued_cnt    (issued_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic load_program_a();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0351;
    mem[1] = 16'h0352;
    mem[2] = 16'hF000;
  endtask

  task automatic do_reset();
    start = 1'b0; core_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge following the edge that saw start (sequencer in FETCH).
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !instr_valid; i++) @(negedge clk);
    n_checks++;
    if (!instr_valid) begin
      n_fails++;
      $display("FAIL %s: instr_valid not seen within %0d cycles", name, budget);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    load_program_a();
    do_reset();
    n_checks++;
    if ({imem_rd_en, instr_valid, halted, busy, pc, imem_addr, instr_out, issued_cnt} !== '0) begin
      n_fails++;
      $display("FAIL reset_idle: rd=%b v=%b h=%b b=%b pc=%h addr=%h instr=%h cnt=%h, want all 0",
               imem_rd_en, instr_valid, halted, busy, pc, imem_addr, instr_out, issued_cnt);
    end
    pulse_start();
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL start_latency_fetch: rd=%b addr=%h busy=%b, want 1 00 1", imem_rd_en, imem_addr, busy);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_out !== 16'h0351) begin
      n_fails++;
      $display("FAIL start_latency_valid: valid=%b instr=%h, want 1 0351", instr_valid, instr_out);
    end
    // Asynchronous reset in the middle of ISSUE.
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_rd_en, instr_valid, halted, busy, pc, imem_addr, instr_out, issued_cnt} !== '0) begin
      n_fails++;
      $display("FAIL reset_mid_issue: rd=%b v=%b h=%b b=%b pc=%h addr=%h instr=%h cnt=%h, want all 0",
               imem_rd_en, instr_valid, halted, busy, pc, imem_addr, instr_out, issued_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_program_halt();
    logic [15:0] got[$];
    int          valid_cycle[$];
    int          cyc = 0;
    load_program_a();
    core_ready = 1'b1;
    pulse_start();
    while (!halted && cyc < 40) begin
      if (instr_valid) begin
        got.push_back(instr_out);
        valid_cycle.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    core_ready = 1'b0;
    n_checks++;
    if (got.size() != 2 || got[0] !== 16'h0351 || got[1] !== 16'h0352) begin
      n_fails++;
      $display("FAIL program_order: issued %0d words (first %h), want 0351 then 0352",
               got.size(), got.size() > 0 ? got[0] : 16'hxxxx);
    end
    n_checks++;
    if (valid_cycle.size() == 2 && valid_cycle[1] - valid_cycle[0] != 3) begin
      n_fails++;
      $display("FAIL throughput: issue spacing %0d cycles, want 3", valid_cycle[1] - valid_cycle[0]);
    end
    n_checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || issued_cnt !== 16'd2 || pc !== 8'd2 || instr_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL program_halt: halted=%b busy=%b cnt=%0d pc=%0d valid=%b, want 1 0 2 2 0",
               halted, busy, issued_cnt, pc, instr_valid);
    end
  endtask

  task automatic test_backpressure();
    load_program_a();
    do_reset();
    pulse_start();
    wait_valid("backpressure_wait", 10);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr_out !== 16'h0351 || issued_cnt !== 16'd0) begin
        n_fails++;
        $display("FAIL backpressure_hold[%0d]: valid=%b instr=%h cnt=%0d, want 1 0351 0",
                 i, instr_valid, instr_out, issued_cnt);
      end
      @(negedge clk);
    end
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || issued_cnt !== 16'd1) begin
      n_fails++;
      $display("FAIL backpressure_accept: valid=%b cnt=%0d, want 0 1", instr_valid, issued_cnt);
    end
    wait_valid("backpressure_next", 10);
    n_checks++;
    if (instr_out !== 16'h0352 || issued_cnt !== 16'd1) begin
      n_fails++;
      $display("FAIL backpressure_single: instr=%h cnt=%0d, want 0352 1", instr_out, issued_cnt);
    end
  endtask

  task automatic test_redirect_wait();
    load_program_a();
    mem[8'h40] = 16'h1234;
    do_reset();
    pulse_start();
    @(negedge clk);                    // now in WAIT with 0351 in flight
    branch_taken = 1'b1;
    branch_target = 8'h40;
    @(negedge clk);
    branch_taken = 1'b0;
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0 || issued_cnt !== 16'd0) begin
      n_fails++;
      $display("FAIL redirect_wait: rd=%b addr=%h valid=%b cnt=%0d, want 1 40 0 0",
               imem_rd_en, imem_addr, instr_valid, issued_cnt);
    end
    wait_valid("redirect_wait_issue", 10);
    n_checks++;
    if (instr_out !== 16'h1234 || issued_cnt !== 16'd0) begin
      n_fails++;
      $display("FAIL redirect_wait_target: instr=%h cnt=%0d, want 1234 0", instr_out, issued_cnt);
    end
  endtask

  task automatic test_accept_and_branch();
    load_program_a();
    mem[8'h10] = 16'h2010;
    do_reset();
    pulse_start();
    wait_valid("accept_branch_wait", 10);
    core_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 8'h10;
    @(negedge clk);
    core_ready = 1'b0;
    branch_taken = 1'b0;
    n_checks++;
    if (issued_cnt !== 16'd1 || imem_rd_en !== 1'b1 || imem_addr !== 8'h10) begin
      n_fails++;
      $display("FAIL accept_branch: cnt=%0d rd=%b addr=%h, want 1 1 10", issued_cnt, imem_rd_en, imem_addr);
    end
    wait_valid("accept_branch_issue", 10);
    n_checks++;
    if (instr_out !== 16'h2010) begin
      n_fails++;
      $display("FAIL accept_branch_target: instr=%h, want 2010", instr_out);
    end
  endtask

  task automatic test_wrap();
    load_program_a();
    mem[8'hFF] = 16'h0AAA;
    do_reset();
    pulse_start();                     // FETCH: redirect straight away
    branch_taken = 1'b1;
    branch_target = 8'hFF;
    @(negedge clk);
    branch_taken = 1'b0;
    wait_valid("wrap_wait", 10);
    n_checks++;
    if (instr_out !== 16'h0AAA || pc !== 8'hFF) begin
      n_fails++;
      $display("FAIL wrap_issue: instr=%h pc=%h, want 0AAA FF", instr_out, pc);
    end
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00 || pc !== 8'h00) begin
      n_fails++;
      $display("FAIL wrap_next: rd=%b addr=%h pc=%h, want 1 00 00", imem_rd_en, imem_addr, pc);
    end
  endtask

  task automatic test_saturation_restart();
    int          accepts = 0;
    int          cyc = 0;
    logic [15:0] exp_cnt;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0351; mem[1] = 16'h0352; mem[2] = 16'h0353; mem[3] = 16'hF000;
    do_reset();
    core_ready = 1'b1;
    pulse_start();
    force dut.issued_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.issued_cnt_q;
    exp_cnt = 16'hFFFE;
    n_checks++;
    if (issued_cnt !== exp_cnt) begin
      n_fails++;
      $display("FAIL sat_preload: cnt=%h, want FFFE", issued_cnt);
    end
    while (!halted && cyc < 40) begin
      if (instr_valid) begin
        accepts++;
        @(negedge clk);
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        n_checks++;
        if (issued_cnt !== exp_cnt) begin
          n_fails++;
          $display("FAIL sat_count[%0d]: cnt=%h, want %h", accepts, issued_cnt, exp_cnt);
        end
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    core_ready = 1'b0;
    n_checks++;
    if (accepts != 3 || issued_cnt !== 16'hFFFF || halted !== 1'b1 || pc !== 8'd3) begin
      n_fails++;
      $display("FAIL sat_final: accepts=%0d cnt=%h halted=%b pc=%0d, want 3 FFFF 1 3",
               accepts, issued_cnt, halted, pc);
    end
    // Redirects are ignored while halted.
    branch_taken = 1'b1;
    branch_target = 8'h55;
    @(negedge clk);
    branch_taken = 1'b0;
    n_checks++;
    if (pc !== 8'd3 || halted !== 1'b1 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL halt_ignores_branch: pc=%h halted=%b busy=%b, want 03 1 0", pc, halted, busy);
    end
    pulse_start();
    n_checks++;
    if (pc !== 8'd0 || issued_cnt !== 16'd0 || halted !== 1'b0 || busy !== 1'b1 || imem_rd_en !== 1'b1) begin
      n_fails++;
      $display("FAIL restart: pc=%h cnt=%h halted=%b busy=%b rd=%b, want 00 0000 0 1 1",
               pc, issued_cnt, halted, busy, imem_rd_en);
    end
  endtask

  // Randomized ready/redirect traffic over a halt-free random program.
  task automatic test_random();
    logic [7:0]  model_pc = 8'h00;
    logic [15:0] model_cnt = 16'd0;
    logic [15:0] w;
    logic        rdy, br, accept;
    logic [7:0]  tgt;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h7;
      mem[i] = w;
    end
    do_reset();
    pulse_start();
    for (int c = 0; c < 1500; c++) begin
      n_checks++;
      if (pc !== model_pc || issued_cnt !== model_cnt || busy !== 1'b1 ||
          (imem_rd_en && imem_addr !== model_pc)) begin
        n_fails++;
        $display("FAIL random_state[%0d]: pc=%h cnt=%0d busy=%b addr=%h, want pc=%h cnt=%0d busy=1",
                 c, pc, issued_cnt, busy, imem_addr, model_pc, model_cnt);
      end
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = 8'($urandom);
      core_ready = rdy;
      branch_taken = br;
      branch_target = tgt;
      accept = instr_valid && rdy;
      if (accept) begin
        n_checks++;
        if (instr_out !== mem[model_pc]) begin
          n_fails++;
          $display("FAIL random_issue[%0d]: instr=%h, want mem[%h]=%h",
                   c, instr_out, model_pc, mem[model_pc]);
        end
        model_cnt = model_cnt + 16'd1;
      end
      if (br)          model_pc = tgt;
      else if (accept) model_pc = model_pc + 8'd1;
      @(negedge clk);
    end
    core_ready = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program_halt();
    test_backpressure();
    test_redirect_wait();
    test_accept_and_branch();
    test_wrap();
    test_saturation_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/minimips_fetch_sequencer.md
# minimips_fetch_sequencer

Instruction fetch and issue controller for the MiniMIPS core. Holds the program counter, reads 16-bit instructions from a synchronous instruction memory, and presents each one to the MiniMIPS datapath's `instruction` input with a valid/ready handshake. It takes branch/jump redirects from the core and stops on a halt opcode. It replaces bench-driven instruction sequencing with an on-chip sequencer.

## Interface
Parameters:
- `IMEM_AW`, 8: instruction memory word-address width; PC width.
- `HALT_OPCODE`, 4'b1111: value of `instr[15:12]` that stops the sequencer.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level; begins fetching from PC 0 when in IDLE or HALT.
- `imem_rd_en` output 1: instruction memory read strobe.
- `imem_addr` output IMEM_AW: read word address (= PC).
- `imem_rdata` input 16: read data, valid exactly one cycle after `imem_rd_en`.
- `instr_out` output 16: instruction to the datapath.
- `instr_valid` output 1: `instr_out` holds an unissued instruction.
- `core_ready` input 1: core accepts `instr_out` this cycle.
- `branch_taken` input 1: one-cycle redirect request.
- `branch_target` input IMEM_AW: redirect word address.
- `pc` output IMEM_AW: current PC.
- `halted` output 1: high in HALT.
- `busy` output 1: high in FETCH, WAIT or ISSUE.
- `issued_cnt` output 16: accepted-instruction counter, saturating at 16'hFFFF.

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, HALT.
- IDLE: `start`=1 -> `pc`<=0, `issued_cnt`<=0, go FETCH.
- FETCH: `imem_rd_en`=1, `imem_addr`=`pc`; go WAIT.
- WAIT: capture `imem_rdata` into the instruction register.
  - `imem_rdata[15:12]`==HALT_OPCODE -> go HALT. The halt instruction is never issued and `pc` is not advanced.
  - Otherwise go ISSUE.
- ISSUE: `instr_valid`=1; `instr_out` is held stable until accepted.
  - On `core_ready`=1: `issued_cnt`++ (saturating), `pc`<=`pc`+1 mod 2^IMEM_AW, go FETCH.
- HALT: `halted`=1. `start`=1 restarts as from IDLE: PC 0, counter cleared.
- Redirect, in FETCH/WAIT/ISSUE: `branch_taken`=1 -> `pc`<=`branch_target`, go FETCH.
  - Any fetched or pending instruction is squashed: not issued, not counted.
  - In-flight `imem_rdata` is ignored.
  - `branch_taken` is ignored in IDLE and HALT.
- Branch and accept together in ISSUE (`core_ready`=1, `branch_taken`=1): the instruction counts as issued, `pc`<=`branch_target` (target wins over +1), go FETCH.
- Branch in WAIT on a halt word: redirect wins and HALT is not entered.
- PC wrap: 2^IMEM_AW-1 + 1 -> 0. There is no error condition.
- `start` held high in FETCH/WAIT/ISSUE has no effect.

## Timing
- Reset (async assert, sync deassert at the next edge):
  - State = IDLE.
  - `pc`=0, `issued_cnt`=0, instruction register=0.
  - `imem_rd_en`=0, `instr_valid`=0, `halted`=0, `busy`=0, `imem_addr`=0, `instr_out`=0.
- Reset mid-operation discards everything, including a pending ISSUE.
- Latency with `core_ready` tied high:
  - `start` seen at edge N -> `imem_rd_en` high in cycle N+1 -> `instr_valid` high in cycle N+3.
  - Steady throughput: 1 instruction per 3 cycles.
- Redirect seen at edge N -> `imem_rd_en` with `imem_addr`=target in cycle N+1.
- `instr_valid` is a registered state decode and never glitches.
- `instr_valid` drops in the cycle after acceptance.
- `instr_out` changes only on the WAIT capture.
- `halted` rises one cycle after the WAIT that sees the halt opcode.

## Structure
- Shared package `minimips_pkg`:
  - State enum `fetch_state_t`.
  - `OPCODE_MSB`/`OPCODE_LSB` = 15/12.
  - `HALT_OPCODE` default.
  - `INSTR_W`=16.
- Sub-module `minimips_pc_unit`: PC register with load (`start` -> 0, redirect -> target) and increment-with-wrap.
- FSM, instruction register and counter live in the top.

## Test plan
- Reset/start: assert `rst_n`=0 mid-ISSUE -> all outputs 0 immediately. Release, pulse `start`, with imem words 0:16'h0351, 1:16'h0352, 2:16'hF000 -> two instructions issued in order, then `halted`=1, `issued_cnt`=2, `pc`=2.
- Backpressure: hold `core_ready`=0 for 5 cycles in ISSUE -> `instr_out` stays 16'h0351 with `instr_valid`=1. Release -> exactly one accept, `issued_cnt`=1.
- Redirect in WAIT: `branch_taken`=1, `branch_target`=8'h40 -> captured word is never issued, next `imem_addr`=8'h40, count unchanged.
- Simultaneous accept and branch to 8'h10 -> `issued_cnt` increments, next fetch address is 8'h10, not PC+1.
- Wrap: redirect to 8'hFF holding a non-halt word, accept -> next `imem_addr`=8'h00.
- Saturation and restart: preload `issued_cnt`=16'hFFFE, then issue 3 instructions -> counter reads 16'hFFFF. From HALT, `start` -> `pc`=0, `issued_cnt`=0, `halted`=0.
